// File: rtl/mix_layer_pkg.sv
// Shared widths, state encoding and defaults for the mix-layer weight fetch path.
`ifndef HID_DIM
`define HID_DIM 4
`endif
`ifndef DATA_N
`define DATA_N 4
`endif
`ifndef N_LEN
`define N_LEN 8
`endif

package mix_layer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam int N_LAYERS_DEF        = 3;
  localparam int WORDS_PER_LAYER_DEF = `HID_DIM * `HID_DIM / `DATA_N;
  localparam int W_DATA_W            = `DATA_N * `N_LEN;
  localparam int ADDR_W              = `N_LEN;
endpackage

// File: rtl/mix_w_fetch_if.sv
// Weight stream from the fetch unit to the MAC array (valid/ready with last marker).
interface mix_w_fetch_if #(
  parameter int DW = `DATA_N * `N_LEN
);
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_last;
  logic          w_ready;

  modport master (output w_data, output w_valid, output w_last, input w_ready);
  modport slave  (input w_data, input w_valid, input w_last, output w_ready);
endinterface

// File: rtl/mix_w_skid_buf.sv
// Two-entry valid/ready buffer carrying a data word plus its last flag; head drives the outputs.
module mix_w_skid_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o,
  output logic [1:0]    count_o
);
  logic [DW-1:0] head_q, head_d, tail_q, tail_d;
  logic          head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop;

  assign pop = (cnt_q != 2'd0) && ready_i;

  always_comb begin
    head_d      = head_q;
    head_last_d = head_last_q;
    tail_d      = tail_q;
    tail_last_d = tail_last_q;
    cnt_d       = cnt_q;
    case ({push_i, pop})
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d      = data_i;
          head_last_d = last_i;
        end else begin
          head_d      = tail_q;
          head_last_d = tail_last_q;
          tail_d      = data_i;
          tail_last_d = last_i;
        end
      end
      2'b01: begin
        head_d      = tail_q;
        head_last_d = tail_last_q;
        cnt_d       = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d      = data_i;
          head_last_d = last_i;
        end else begin
          tail_d      = data_i;
          tail_last_d = last_i;
        end
        cnt_d = cnt_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      head_q      <= '0;
      head_last_q <= 1'b0;
      tail_q      <= '0;
      tail_last_q <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      head_q      <= head_d;
      head_last_q <= head_last_d;
      tail_q      <= tail_d;
      tail_last_q <= tail_last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = head_q;
  assign last_o  = valid_o && head_last_q;
  assign count_o = cnt_q;
endmodule

// File: rtl/mix_w_fetch.sv
// Streams one weight matrix from the ROM into the MAC array; optional stall counter
// enabled by MIX_W_FETCH_STALL_CNT_EN. rst_n is active-high synchronous.
//   state | meaning
//   IDLE  | waiting for start with a valid layer_sel
//   FETCH | issuing ROM reads base+k, throttled by buffer space
//   DRAIN | all reads issued, waiting for the w_last transfer
module mix_w_fetch
  import mix_layer_pkg::*;
#(
  parameter int WORDS_PER_LAYER = WORDS_PER_LAYER_DEF,
  parameter int N_LAYERS        = N_LAYERS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          layer_sel,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [W_DATA_W-1:0] rom_data,
  mix_w_fetch_if.master       w_if
`ifdef MIX_W_FETCH_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);
  localparam int REM_W = $clog2(WORDS_PER_LAYER + 1);

  if (N_LAYERS * WORDS_PER_LAYER - 1 >= (1 << ADDR_W)) begin : g_addr_range_err
    $error("mix_w_fetch: rom_addr too narrow for N_LAYERS*WORDS_PER_LAYER");
  end

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d, addr_q, addr_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              infl_q, infl_d, infl_last_q, infl_last_d;
  logic              done_q, done_d;
  logic [1:0]        buf_cnt;
  logic              pop, start_ok, issue;

  assign pop      = w_if.w_valid && w_if.w_ready;
  assign start_ok = start && (int'(layer_sel) < N_LAYERS);
  // Count the head leaving this cycle so a full-rate stream keeps issuing.
  assign issue    = (state_q == ST_FETCH) &&
                    (({1'b0, buf_cnt} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));
  assign rom_addr = issue ? next_addr_q : addr_q;

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    infl_d      = issue;
    infl_last_d = issue && (rem_q == '0);
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d     = ST_FETCH;
          next_addr_d = ADDR_W'(int'(layer_sel) * WORDS_PER_LAYER);
          rem_d       = REM_W'(WORDS_PER_LAYER - 1);
        end
      end
      ST_FETCH: begin
        if (issue) begin
          addr_d      = next_addr_q;
          next_addr_d = next_addr_q + 1'b1;
          if (rem_q == '0) state_d = ST_DRAIN;
          else             rem_d   = rem_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (pop && w_if.w_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      next_addr_q <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

  mix_w_skid_buf #(.DW(W_DATA_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (infl_q),
    .data_i  (rom_data),
    .last_i  (infl_last_q),
    .ready_i (w_if.w_ready),
    .valid_o (w_if.w_valid),
    .data_o  (w_if.w_data),
    .last_o  (w_if.w_last),
    .count_o (buf_cnt)
  );

`ifdef MIX_W_FETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && start_ok)
      stall_d = '0;
    else if (w_if.w_valid && !w_if.w_ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_mix_w_fetch.sv
// Directed bench for mix_w_fetch with WORDS_PER_LAYER=4 and a ROM whose word equals its address.
module tb_mix_w_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  layer_sel = 2'd0;
  logic        busy, done;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data = 32'd0;
`ifdef MIX_W_FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int n_tests = 0;
  int n_fail  = 0;

  mix_w_fetch_if #(.DW(32)) w_if ();

  mix_w_fetch #(.WORDS_PER_LAYER(4), .N_LAYERS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .layer_sel (layer_sel),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .w_if      (w_if.master)
`ifdef MIX_W_FETCH_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= {24'd0, rom_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chkb({tag, "_busy"}, busy, 1'b0);
    chkb({tag, "_done"}, done, 1'b0);
    chkb({tag, "_wvalid"}, w_if.w_valid, 1'b0);
    chkb({tag, "_wlast"}, w_if.w_last, 1'b0);
    chk({tag, "_romaddr"}, {24'd0, rom_addr}, 32'd0);
    chk({tag, "_wdata"}, w_if.w_data, 32'd0);
  endtask

  // Collects transfers until done (bounded); mode 1 toggles w_ready 1,0,1,0.
  task automatic drain(input int first, input int nwords, input int mode, input bit inject);
    int          got = 0;
    int          cyc = 0;
    logic [31:0] prev_d = 32'd0;
    logic        prev_stall = 1'b0;
    bit          seen_done = 1'b0;
    while (!seen_done && cyc < 40) begin
      @(negedge clk);
      w_if.w_ready = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      start = inject && (cyc == 2);
      if (inject && cyc == 2) layer_sel = 2'd0;
      #1;
      if (prev_stall) begin
        chkb("hold_valid", w_if.w_valid, 1'b1);
        chk("hold_data", w_if.w_data, prev_d);
      end
      if (w_if.w_valid && w_if.w_ready) begin
        chk("word", w_if.w_data, first + got);
        chkb("last_flag", w_if.w_last, got == nwords - 1);
        got++;
      end
      if (done) begin
        seen_done = 1'b1;
        chkb("busy_at_done", busy, 1'b0);
      end
      prev_stall = w_if.w_valid && !w_if.w_ready;
      prev_d = w_if.w_data;
      cyc++;
    end
    start = 1'b0;
    chk("word_count", got, nwords);
    chkb("done_seen", seen_done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int e_addr[7]  = '{4, 5, 6, 7, 7, 7, 7};
    bit e_valid[7] = '{0, 0, 1, 1, 1, 1, 0};
    int e_data[7]  = '{0, 0, 4, 5, 6, 7, 0};
    bit e_last[7]  = '{0, 0, 0, 0, 0, 1, 0};
    bit e_busy[7]  = '{1, 1, 1, 1, 1, 1, 0};
    bit e_done[7]  = '{0, 0, 0, 0, 0, 0, 1};
    w_if.w_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("post_rst");

    // Layer 1, w_ready held high
    @(negedge clk);
    start = 1'b1; layer_sel = 2'd1; w_if.w_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("l1_romaddr", {24'd0, rom_addr}, e_addr[i]);
      chkb("l1_wvalid", w_if.w_valid, e_valid[i]);
      if (e_valid[i]) chk("l1_wdata", w_if.w_data, e_data[i]);
      chkb("l1_wlast", w_if.w_last, e_last[i]);
      chkb("l1_busy", busy, e_busy[i]);
      chkb("l1_done", done, e_done[i]);
    end
    @(negedge clk);
    #1;
    chkb("l1_done_pulse_end", done, 1'b0);

    // Layer 2 with toggling ready and a start(layer 0) injected mid-stream
    @(negedge clk);
    start = 1'b1; layer_sel = 2'd2; w_if.w_ready = 1'b1;
    drain(8, 4, 1, 1'b1);

    // Out-of-range layer is ignored
    @(negedge clk);
    start = 1'b1; layer_sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chkb("bad_sel_busy", busy, 1'b0);
      chkb("bad_sel_wvalid", w_if.w_valid, 1'b0);
      chk("bad_sel_romaddr", {24'd0, rom_addr}, 32'd11);
    end

    // Layer 0 with w_ready low for 7 cycles: issue stalls with rom_addr held
    @(negedge clk);
    start = 1'b1; layer_sel = 2'd0; w_if.w_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("stall_romaddr", {24'd0, rom_addr}, (i == 1) ? 32'd0 : 32'd1);
      if (i >= 3) begin
        chkb("stall_wvalid", w_if.w_valid, 1'b1);
        chk("stall_wdata", w_if.w_data, 32'd0);
      end
    end
    @(negedge clk);
    w_if.w_ready = 1'b1;
    #1;
`ifdef MIX_W_FETCH_STALL_CNT_EN
    chk("stall_cnt_5", {16'd0, stall_cnt}, 32'd5);
`endif
    chk("stall_first_word", w_if.w_data, 32'd0);
    chkb("stall_first_valid", w_if.w_valid, 1'b1);
    drain(1, 3, 0, 1'b0);

    // Layer 1 aborted by reset after the second transfer, then restarted
    @(negedge clk);
    start = 1'b1; layer_sel = 2'd1; w_if.w_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
`ifdef MIX_W_FETCH_STALL_CNT_EN
    chk("stall_cnt_clr", {16'd0, stall_cnt}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort_w0", w_if.w_data, 32'd4);
    @(negedge clk);
    #1;
    chk("abort_w1", w_if.w_data, 32'd5);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    #1;
    chkb("abort_no_done", done, 1'b0);
    chkb("abort_idle", busy, 1'b0);
    @(negedge clk);
    start = 1'b1; layer_sel = 2'd1;
    drain(4, 4, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mix_w_fetch.md
MIX_W_FETCH -- requirements
Module: mix_w_fetch

Interface
REQ-001 SHALL have parameter WORDS_PER_LAYER, default `HID_DIM*`HID_DIM/`DATA_N, weight words per mix-layer matrix.
REQ-002 SHALL have parameter N_LAYERS, default 3, number of matrices held back-to-back in the weight ROM.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst_n  in  1  synchronous, active-high reset (asserted = 1, sampled on clk).
REQ-005 Port: start  in  1  one-cycle request to stream one matrix.
REQ-006 Port: layer_sel  in  2  matrix index, 0..N_LAYERS-1, sampled with start.
REQ-007 Port: busy  out  1  high from accepted start until done.
REQ-008 Port: done  out  1  one-cycle pulse after last word handed off.
REQ-009 Port: rom_addr  out  `N_LEN  read address to weight ROM.
REQ-010 Port: rom_data  in  `DATA_N*`N_LEN  ROM read data, valid exactly 1 cycle after rom_addr is presented.
REQ-011 Port: w_data  out  `DATA_N*`N_LEN  weight word to downstream MAC array.
REQ-012 Port: w_valid  out  1  w_data valid.
REQ-013 Port: w_ready  in  1  downstream accepts; transfer when w_valid && w_ready.
REQ-014 Port: w_last  out  1  marks final word of the matrix, qualified by w_valid.

Function
REQ-015 States SHALL be IDLE, FETCH, DRAIN.
REQ-016 IDLE->FETCH on start with layer_sel < N_LAYERS; base = layer_sel*WORDS_PER_LAYER latched; start with layer_sel >= N_LAYERS ignored, stays IDLE.
REQ-017 start while busy SHALL be ignored, no effect on current stream.
REQ-018 FETCH SHALL issue rom_addr = base+k, k = 0..WORDS_PER_LAYER-1 ascending, at most one per cycle.
REQ-019 A read SHALL be issued only when (skid-buffer occupancy + reads in flight) < 2; ROM data captured into the buffer the cycle after issue.
REQ-020 FETCH->DRAIN in the cycle after address k = WORDS_PER_LAYER-1 is issued.
REQ-021 DRAIN->IDLE when the word carrying w_last is transferred; done pulses the following cycle, busy falls with done.
REQ-022 w_data/w_valid/w_last SHALL be driven from the 2-entry skid buffer head; words appear in address order, none dropped or duplicated.
REQ-023 With w_ready held 1, throughput SHALL be one word per cycle; first w_valid 2 cycles after accepted start.
REQ-024 w_valid, once high, SHALL stay high and w_data stable until transferred.
REQ-025 Buffer full and no read in flight SHALL stall address issue; rom_addr holds its last value while stalled.
REQ-026 WORDS_PER_LAYER = 1: single word, w_last on it.

Reset
REQ-027 rst_n = 1 SHALL force IDLE, busy=0, done=0, w_valid=0, w_last=0, rom_addr=0, buffer empty, in-flight cleared, w_data=0.
REQ-028 Reset mid-stream SHALL abort; no done pulse; the next accepted start restarts from k = 0.

Configuration
REQ-029 Macro MIX_W_FETCH_STALL_CNT_EN defined: extra output stall_cnt [15:0] counts cycles with w_valid && !w_ready, saturates at 16'hFFFF, cleared on reset and on accepted start.
REQ-030 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-031 State enum, N_LAYERS default and WORDS_PER_LAYER expression SHALL live in shared package mix_layer_pkg; widths from consts.vh macros.
REQ-032 `N_LEN SHALL be wide enough for N_LAYERS*WORDS_PER_LAYER-1; elaboration check required.
REQ-033 Sub-module mix_w_skid_buf (2-entry valid/ready buffer, data width `DATA_N*`N_LEN plus last bit) SHALL be separate.

Verification (bench overrides WORDS_PER_LAYER=4, ROM model word = address)
REQ-034 start, layer_sel=1, w_ready=1 -> rom_addr 4,5,6,7 on consecutive cycles; w_data 4,5,6,7, w_last on 7; done 1 cycle after; busy 1 throughout.
REQ-035 layer_sel=2, w_ready toggling 1,0,1,0 -> words 8..11 in order, each held stable while w_ready=0, no loss or duplicate.
REQ-036 layer_sel=3 with start -> busy stays 0, no rom_addr change, no w_valid.
REQ-037 start with layer_sel=0 during an active layer_sel=2 stream -> ignored; only words 8..11 emitted.
REQ-038 rst_n=1 after second transfer of layer 1 -> all outputs to reset values, no done; new start layer 1 -> words 4..7 complete.
REQ-039 MIX_W_FETCH_STALL_CNT_EN defined, w_ready=0 for 5 cycles with w_valid high -> stall_cnt = 5; next start -> stall_cnt = 0.
